frame_fill_engine: RTL and testbench

Hardware rectangle-fill accelerator on the CPU clock domain, upstream of the 1024x768x1-bit frame buffer. It accepts one rectangle command at a time and emits one framebuffer write per cycle, row-major, on the frame buffer's write port (`arb_*`). This offloads the CPU from per-pixel stores. The DVI controller reads the same buffer on the pixel clock.

---
 rtl/frame_fill_engine.sv | 131 +++++++++++++
 tb/tb_frame_fill_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/frame_fill_engine.sv
// Rectangle-fill engine: one framebuffer write per cycle, row-major, address {y, x}.
// Optional FILL_CLIP_EN clamps fills to the visible rows (0..V_PIXELS-1).
module frame_fill_engine #(
   parameter int unsigned H_PIXELS = 1024,
   parameter int unsigned V_PIXELS = 768
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x0,
   input  logic [9:0]  cmd_x1,
   input  logic [9:0]  cmd_y0,
   input  logic [9:0]  cmd_y1,
   input  logic        cmd_color,
   output logic        fb_we,
   output logic [19:0] fb_addr,
   output logic        fb_din,
   output logic        busy,
   output logic        done
);

   localparam int unsigned X_W = $clog2(H_PIXELS);
   localparam int unsigned Y_W = $clog2(V_PIXELS);
`ifdef FILL_CLIP_EN
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);
`endif

   typedef enum logic {IDLE, FILL} state_e;

   state_e         state_q, state_d;
   logic [X_W-1:0] x_q, x_d, x_lo_q, x_lo_d, x_hi_q, x_hi_d;
   logic [Y_W-1:0] y_q, y_d, y_hi_q, y_hi_d;
   logic           fb_we_q, fb_we_d, fb_din_q, fb_din_d, done_q, done_d;
   logic [X_W-1:0] cx_lo, cx_hi;
   logic [Y_W-1:0] cy_lo, cy_hi;

   // Corner normalization, only consumed on the accept edge
   always_comb begin
      cx_lo = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
      cx_hi = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
      cy_lo = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
      cy_hi = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
`ifdef FILL_CLIP_EN
      if (cy_hi > Y_LAST) begin
         cy_hi = Y_LAST;
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      x_lo_d   = x_lo_q;
      x_hi_d   = x_hi_q;
      y_hi_d   = y_hi_q;
      fb_we_d  = fb_we_q;
      fb_din_d = fb_din_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               x_lo_d   = cx_lo;
               x_hi_d   = cx_hi;
               y_hi_d   = cy_hi;
               x_d      = cx_lo;
               y_d      = cy_lo;
               fb_din_d = cmd_color;
`ifdef FILL_CLIP_EN
               // Entirely below the visible area: accepted, zero writes
               if (cy_lo > Y_LAST) begin
                  done_d = 1'b1;
               end else begin
                  fb_we_d = 1'b1;
                  state_d = FILL;
               end
`else
               fb_we_d = 1'b1;
               state_d = FILL;
`endif
            end
         end
         FILL: begin
            if ((x_q == x_hi_q) && (y_q == y_hi_q)) begin
               fb_we_d = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (x_q == x_hi_q) begin
               x_d = x_lo_q;
               y_d = y_q + Y_W'(1);
            end else begin
               x_d = x_q + X_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         x_lo_q   <= '0;
         x_hi_q   <= '0;
         y_hi_q   <= '0;
         fb_we_q  <= 1'b0;
         fb_din_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         x_lo_q   <= x_lo_d;
         x_hi_q   <= x_hi_d;
         y_hi_q   <= y_hi_d;
         fb_we_q  <= fb_we_d;
         fb_din_q <= fb_din_d;
         done_q   <= done_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign fb_we     = fb_we_q;
   assign fb_addr   = {y_q, x_q};
   assign fb_din    = fb_din_q;
   assign done      = done_q;

endmodule

// File: tb/tb_frame_fill_engine.sv
// Self-checking bench for frame_fill_engine: directed cases plus random rectangles
// checked against a pixel-list model; honours FILL_CLIP_EN like the design.
module tb_frame_fill_engine;

   localparam int V_PIX = 768;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [9:0]  cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
   logic        cmd_color = 1'b0;
   logic        fb_we;
   logic [19:0] fb_addr;
   logic        fb_din;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   frame_fill_engine dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x0    (cmd_x0),
      .cmd_x1    (cmd_x1),
      .cmd_y0    (cmd_y0),
      .cmd_y1    (cmd_y1),
      .cmd_color (cmd_color),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_din    (fb_din),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_we"}, 32'(fb_we), 0);
      chk({tag, "_ready"}, 32'(cmd_ready), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk_idle("idle");
         chk("idle_done", 32'(done), 0);
      end
   endtask

   // Entered and left on a falling edge; the next call may accept on the edge after done.
   task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                          input bit color, input int abort_at);
      int xl, xh, yl, yh;
      int q[$];
      xl = (x0 < x1) ? x0 : x1;
      xh = (x0 < x1) ? x1 : x0;
      yl = (y0 < y1) ? y0 : y1;
      yh = (y0 < y1) ? y1 : y0;
`ifdef FILL_CLIP_EN
      if (yh > V_PIX - 1) yh = V_PIX - 1;
`endif
      for (int y = yl; y <= yh; y++)
         for (int x = xl; x <= xh; x++)
            q.push_back(y * 1024 + x);

      chk("ready_at_accept", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_x0 = 10'(x0);
      cmd_x1 = 10'(x1);
      cmd_y0 = 10'(y0);
      cmd_y1 = 10'(y1);
      cmd_color = color;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < q.size(); k++) begin
         chk("wr_we", 32'(fb_we), 1);
         chk("wr_addr", 32'(fb_addr), 32'(q[k]));
         chk("wr_din", 32'(fb_din), 32'(color));
         chk("wr_ready", 32'(cmd_ready), 0);
         chk("wr_busy", 32'(busy), 1);
         chk("wr_done", 32'(done), 0);
         if (k == abort_at) begin
            cmd_valid = 1'b0;
            #1 rst = 1'b1;
            #1;
            chk("rst_we", 32'(fb_we), 0);
            chk("rst_addr", 32'(fb_addr), 0);
            chk("rst_din", 32'(fb_din), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ready", 32'(cmd_ready), 1);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         // Command inputs must be ignored while busy
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_x0 = 10'($urandom);
         cmd_x1 = 10'($urandom);
         cmd_y0 = 10'($urandom);
         cmd_y1 = 10'($urandom);
         cmd_color = 1'($urandom);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("end_we", 32'(fb_we), 0);
      chk("end_done", 32'(done), 1);
      chk("end_ready", 32'(cmd_ready), 1);
      chk("end_busy", 32'(busy), 0);
   endtask

   initial begin
      int x0, x1, y0, y1, t;
      rst = 1'b1;
      @(negedge clk);
      chk("reset_we", 32'(fb_we), 0);
      chk("reset_addr", 32'(fb_addr), 0);
      chk("reset_din", 32'(fb_din), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_ready", 32'(cmd_ready), 1);
      rst = 1'b0;
      idle_cycles(2);

      run_cmd(3, 5, 2, 3, 1'b1, -1);
      idle_cycles(1);
      run_cmd(5, 3, 3, 2, 1'b1, -1);
      run_cmd(1023, 1023, 767, 767, 1'b0, -1);
      idle_cycles(1);

      // Back-to-back: wide multi-row fill then an immediately queued command
      run_cmd(0, 1023, 0, 2, 1'b1, -1);
      run_cmd(10, 12, 20, 20, 1'b0, -1);
      idle_cycles(1);

      // Reset while writing row 1 of a 10x10 fill, then a clean restart
      run_cmd(0, 9, 0, 9, 1'b1, 13);
      run_cmd(4, 6, 7, 8, 1'b1, -1);
      idle_cycles(1);

      run_cmd(0, 0, 700, 900, 1'b1, -1);
      idle_cycles(1);
      run_cmd(0, 0, 900, 800, 1'b0, -1);
      idle_cycles(1);

      for (int i = 0; i < 20; i++) begin
         x0 = $urandom_range(0, 1023);
         x1 = x0 + $urandom_range(0, 7);
         if (x1 > 1023) x1 = 1023;
         y0 = (i % 3 == 0) ? $urandom_range(760, 1023) : $urandom_range(0, 1023);
         y1 = y0 + $urandom_range(0, 6);
         if (y1 > 1023) y1 = 1023;
         if ($urandom_range(0, 1) == 1) begin t = x0; x0 = x1; x1 = t; end
         if ($urandom_range(0, 1) == 1) begin t = y0; y0 = y1; y1 = t; end
         run_cmd(x0, x1, y0, y1, 1'($urandom_range(0, 1)), -1);
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
